spi_target: RTL

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync.sv | 44 ++++
 rtl/spi_target.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI target slice: default frame length,
// the master bit rate the design is characterised against, and the
// frame state encoding used by spi_target.
package spi_pkg;

  // Frame length in bits, shifted MSB first.
  localparam int BITS_PER_TRANSACTION = 16;

  // Reference master rate in S_AXI_ACLK cycles per SPI bit.
  localparam int CLOCKS_PER_BIT = 20;

  // Frame states: IDLE between frames, SHIFT while bits move,
  // HOLD after a complete word until chip select is released.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// spi_sync
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
// Ports:
//   S_AXI_ACLK    clock
//   S_AXI_ARESET  synchronous active-high reset (chain loads RESET_VAL)
//   async_in      asynchronous input pin
//   sync_out      synchronized level
//   rise / fall   one-cycle edge pulses on sync_out
// STAGES must be at least 2.
module spi_sync
  import spi_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESET,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // The edge reference flop resets to the same value as the chain so that
  // reset release never fabricates an edge on its own.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign rise     = sync_out & ~prev;
  assign fall     = ~sync_out & prev;

endmodule

// File: rtl/spi_target.sv
// spi_target
// SPI target (CPOL=1, CPHA=1) with valid/ready word interfaces.
// mosi is sampled on sclk rising edges, sdin_out changes on sclk falling
// edges. All pins are synchronized before use.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET    clock, synchronous active-high reset
//   cs, sclk, mosi              SPI pins from the master (asynchronous)
//   sdin_out                    serial data back to the master
//   tx_data/tx_valid/tx_ready   word to send in the next frame
//   rx_data/rx_valid/rx_ready   last received word
//   busy                        frame in progress (SHIFT or HOLD)
//   overrun/underrun/frame_err  one-cycle event pulses
module spi_target
  import spi_pkg::*;
#(
  parameter int BITS_PER_TRANSACTION = spi_pkg::BITS_PER_TRANSACTION,
  parameter int SYNC_STAGES          = 2
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic                            cs,
  input  logic                            sclk,
  input  logic                            mosi,
  output logic                            sdin_out,
  input  logic [BITS_PER_TRANSACTION-1:0] tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic [BITS_PER_TRANSACTION-1:0] rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic                            busy,
  output logic                            overrun,
  output logic                            underrun,
  output logic                            frame_err
);

  localparam int B     = BITS_PER_TRANSACTION;
  localparam int CNT_W = $clog2(B + 1);

  logic cs_level_unused, cs_rise, cs_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [B-2:0]       rx_shift;
  logic [B-1:0]       rx_next;
  logic [B-1:0]       tx_shift;
  logic [B-1:0]       tx_hold;
  logic               tx_full;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .S_AXI_ACLK  (S_AXI_ACLK),
    .S_AXI_ARESET(S_AXI_ARESET),
    .async_in    (cs),
    .sync_out    (cs_level_unused),
    .rise        (cs_rise),
    .fall        (cs_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .S_AXI_ACLK  (S_AXI_ACLK),
    .S_AXI_ARESET(S_AXI_ARESET),
    .async_in    (sclk),
    .sync_out    (sclk_level_unused),
    .rise        (sclk_rise),
    .fall        (sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .S_AXI_ACLK  (S_AXI_ACLK),
    .S_AXI_ARESET(S_AXI_ARESET),
    .async_in    (mosi),
    .sync_out    (mosi_sync),
    .rise        (mosi_rise_unused),
    .fall        (mosi_fall_unused)
  );

  // The full word including the bit arriving on this rising edge; the
  // shift register only needs B-1 bits of history.
  assign rx_next  = {rx_shift, mosi_sync};
  assign tx_ready = ~tx_full;
  assign busy     = (state != IDLE);

  // Frame FSM plus the tx/rx holding registers. The rx handshake clear is
  // written before the FSM so a word completing in the same cycle wins and
  // rx_valid stays high. The tx load is written after the FSM so a load in
  // the frame-start cycle refills the holding register for the next frame.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_hold   <= '0;
      tx_full   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      sdin_out  <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          sdin_out <= 1'b0;
          if (cs_fall) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            rx_shift <= '0;
            if (tx_full) begin
              tx_shift <= tx_hold;
              sdin_out <= tx_hold[B-1];
              tx_full  <= 1'b0;
            end else begin
              tx_shift <= '0;
              underrun <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            state    <= IDLE;
            sdin_out <= 1'b0;
            if (bit_cnt != '0) begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            rx_shift <= rx_next[B-2:0];
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(B - 1)) begin
              state    <= HOLD;
              sdin_out <= 1'b0;
              if (rx_valid && !rx_ready) begin
                overrun <= 1'b1;
              end else begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
              end
            end
          end else if (sclk_fall && bit_cnt != '0) begin
            // The leading falling edge before the first rise is ignored:
            // the MSB is already on the pin from frame start.
            sdin_out <= tx_shift[B-2];
            tx_shift <= tx_shift << 1;
          end
        end

        HOLD: begin
          sdin_out <= 1'b0;
          if (cs_rise) begin
            state <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          sdin_out <= 1'b0;
        end
      endcase

      if (tx_valid && !tx_full) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end
    end
  end

endmodule
